// File: rtl/spiflash_rdcache_pkg.sv
// Shared types and sizing helpers for the SPI flash read cache.
package spiflash_rdcache_pkg;

    localparam int ADDR_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Tag covers every word-address bit above the offset and index fields.
    function automatic int calc_tag_w(input int lines, input int line_words);
        return 22 - $clog2(line_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/spiflash_rdcache_store.sv
// Tag/valid/data arrays of the read cache: registered read port, word write,
// tag write with optional valid set, single-line invalidate and flush-all.
module spiflash_rdcache_store
    import spiflash_rdcache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4,
    localparam int OFS_W     = $clog2(LINE_WORDS),
    localparam int IDX_W     = $clog2(LINES),
    localparam int TAG_W     = calc_tag_w(LINES, LINE_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_rd_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFS_W-1:0] i_rd_off,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [31:0]      o_rd_word,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFS_W-1:0] i_wr_off,
    input  logic [31:0]      i_wr_data,
    input  logic             i_inv_en,
    input  logic [IDX_W-1:0] i_inv_idx,
    input  logic             i_tag_we,
    input  logic [IDX_W-1:0] i_tag_idx,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_tag_set_valid
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES*LINE_WORDS];

    // Valid bits: cleared by reset or flush, per-line invalidate, set at fill end.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_valid <= {LINES{1'b0}};
        end else begin
            if (i_inv_en) begin
                r_valid[i_inv_idx] <= 1'b0;
            end
            if (i_tag_we && i_tag_set_valid) begin
                r_valid[i_tag_idx] <= 1'b1;
            end
        end
    end

    // Tag and data array writes (contents are meaningless until valid is set).
    always_ff @(posedge clk) begin
        if (i_tag_we) begin
            r_tag[i_tag_idx] <= i_tag;
        end
        if (i_wr_en) begin
            r_data[{i_wr_idx, i_wr_off}] <= i_wr_data;
        end
    end

    // One-cycle read port; a concurrent flush masks the valid being read.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_rd_valid <= 1'b0;
            o_rd_tag   <= {TAG_W{1'b0}};
            o_rd_word  <= 32'h0000_0000;
        end else if (i_rd_en) begin
            o_rd_valid <= r_valid[i_rd_idx] & ~i_flush;
            o_rd_tag   <= r_tag[i_rd_idx];
            o_rd_word  <= r_data[{i_rd_idx, i_rd_off}];
        end
    end

endmodule

// File: rtl/spiflash_rdcache.sv
// Direct-mapped read-only line cache between the PicoRV32 memory port and
// the SPI flash controller read port; misses stream a whole line in order.
module spiflash_rdcache
    import spiflash_rdcache_pkg::*;
#(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_rdata,
    output logic              flash_valid,
    input  logic              flash_ready,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic [31:0]       flash_rdata,
    input  logic              cache_flush,
    output logic              stat_hit,
    output logic              stat_miss
);

    localparam int OFS_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = calc_tag_w(LINES, LINE_WORDS);
    localparam logic [OFS_W-1:0] LAST_OFS = OFS_W'(LINE_WORDS - 1);
    localparam logic [OFS_W-1:0] ONE_OFS  = OFS_W'(1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_req_addr;
    logic [OFS_W-1:0]  r_fill_cnt;
    logic [ADDR_W-1:0] r_flash_addr;
    logic              r_flash_valid;
    logic              r_mem_ready;
    logic [31:0]       r_mem_rdata;
    logic              r_stat_hit;
    logic              r_stat_miss;
    logic [31:0]       r_resp_word;
    logic              r_flush_pend;

    logic              w_accept;
    logic              w_hit;
    logic              w_fill_xfer;
    logic              w_last;
    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [31:0]       w_rd_word;
    logic [OFS_W-1:0]  w_req_off;
    logic [IDX_W-1:0]  w_req_idx;
    logic [TAG_W-1:0]  w_req_tag;
    logic [ADDR_W-1:0] w_line_base;
    logic              w_unused;

    assign w_req_off   = r_req_addr[2+OFS_W-1:2];
    assign w_req_idx   = r_req_addr[2+OFS_W+IDX_W-1:2+OFS_W];
    assign w_req_tag   = r_req_addr[ADDR_W-1:ADDR_W-TAG_W];
    assign w_line_base = {r_req_addr[ADDR_W-1:2+OFS_W], {(OFS_W+2){1'b0}}};
    assign w_unused    = ^r_req_addr[1:0];

    // The mem_ready guard stops the still-high mem_valid of a finished request being re-accepted.
    assign w_accept    = (r_state == IDLE) && mem_valid && !r_mem_ready;
    assign w_hit       = w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_fill_xfer = (r_state == FILL) && flash_ready;
    assign w_last      = (r_fill_cnt == LAST_OFS);

    spiflash_rdcache_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_store (
        .clk             (clk),
        .reset           (reset),
        .i_flush         (cache_flush),
        .i_rd_en         (w_accept),
        .i_rd_idx        (mem_addr[2+OFS_W+IDX_W-1:2+OFS_W]),
        .i_rd_off        (mem_addr[2+OFS_W-1:2]),
        .o_rd_valid      (w_rd_valid),
        .o_rd_tag        (w_rd_tag),
        .o_rd_word       (w_rd_word),
        .i_wr_en         (w_fill_xfer),
        .i_wr_idx        (w_req_idx),
        .i_wr_off        (r_fill_cnt),
        .i_wr_data       (flash_rdata),
        .i_inv_en        ((r_state == LOOKUP) && !w_hit),
        .i_inv_idx       (w_req_idx),
        .i_tag_we        (w_fill_xfer && w_last),
        .i_tag_idx       (w_req_idx),
        .i_tag           (w_req_tag),
        .i_tag_set_valid (!r_flush_pend && !cache_flush)
    );

    // Control FSM with all host- and flash-facing outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_req_addr    <= {ADDR_W{1'b0}};
            r_fill_cnt    <= {OFS_W{1'b0}};
            r_flash_addr  <= {ADDR_W{1'b0}};
            r_flash_valid <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_mem_rdata   <= 32'h0000_0000;
            r_stat_hit    <= 1'b0;
            r_stat_miss   <= 1'b0;
            r_resp_word   <= 32'h0000_0000;
            r_flush_pend  <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;
            r_stat_hit  <= 1'b0;
            r_stat_miss <= 1'b0;
            if (cache_flush && (r_state == FILL)) begin
                r_flush_pend <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_addr <= mem_addr;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_mem_ready <= 1'b1;
                        r_mem_rdata <= w_rd_word;
                        r_stat_hit  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_stat_miss   <= 1'b1;
                        r_fill_cnt    <= {OFS_W{1'b0}};
                        r_flash_addr  <= w_line_base;
                        r_flash_valid <= 1'b1;
                        r_flush_pend  <= 1'b0;
                        r_state       <= FILL;
                    end
                end
                FILL: begin
                    if (flash_ready) begin
                        r_fill_cnt <= r_fill_cnt + ONE_OFS;
                        if (r_fill_cnt == w_req_off) begin
                            r_resp_word <= flash_rdata;
                        end
                        // Response is presented in RESP, so the final word may bypass r_resp_word.
                        if (w_last) begin
                            r_flash_valid <= 1'b0;
                            r_mem_ready   <= 1'b1;
                            r_mem_rdata   <= (w_req_off == LAST_OFS) ? flash_rdata : r_resp_word;
                            r_state       <= RESP;
                        end else begin
                            r_flash_addr <= r_flash_addr + 24'd4;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_ready   = r_mem_ready;
    assign mem_rdata   = r_mem_rdata;
    assign flash_valid = r_flash_valid;
    assign flash_addr  = r_flash_addr;
    assign stat_hit    = r_stat_hit;
    assign stat_miss   = r_stat_miss;

endmodule

// File: tb/tb_spiflash_rdcache.sv
// Scoreboard bench for spiflash_rdcache with a stalling flash model.
module tb_spiflash_rdcache;

    localparam int BUDGET = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [23:0] mem_addr = 24'h0;
    logic [31:0] mem_rdata;
    logic        flash_valid;
    logic        flash_ready;
    logic [23:0] flash_addr;
    logic [31:0] flash_rdata;
    logic        cache_flush = 1'b0;
    logic        stat_hit;
    logic        stat_miss;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    spiflash_rdcache #(.LINES(16), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .flash_valid(flash_valid),
        .flash_ready(flash_ready), .flash_addr(flash_addr), .flash_rdata(flash_rdata),
        .cache_flush(cache_flush), .stat_hit(stat_hit), .stat_miss(stat_miss)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        logic [31:0] w;
        w = {8'h00, a[23:2], 2'b00} * 32'h9E37_79B1;
        return w ^ 32'h5A5A_0F0F;
    endfunction

    // Flash model: word delivered after a random number of wait cycles.
    int unsigned wait_cnt = 0;
    int unsigned max_stall = 0;
    assign flash_ready = flash_valid && (wait_cnt == 0);
    assign flash_rdata = flash_word(flash_addr);

    always @(posedge clk) begin
        if (reset) wait_cnt <= 0;
        else if (flash_valid && flash_ready) wait_cnt <= $urandom_range(max_stall, 0);
        else if (flash_valid && wait_cnt != 0) wait_cnt <= wait_cnt - 1;
    end

    // Monitor: log flash transfers, count miss pulses, watch address stability.
    logic [23:0] flash_log [0:255];
    int   flash_cnt = 0;
    int   miss_cnt = 0;
    int   stall_checks = 0;
    int   stall_errs = 0;
    logic prev_wait = 1'b0;
    logic [23:0] prev_addr = 24'h0;

    always @(negedge clk) begin
        if (flash_valid && flash_ready) begin
            flash_log[flash_cnt[7:0]] <= flash_addr;
            flash_cnt <= flash_cnt + 1;
        end
        if (stat_miss === 1'b1) miss_cnt <= miss_cnt + 1;
        if (flash_valid && prev_wait) begin
            stall_checks <= stall_checks + 1;
            if (flash_addr !== prev_addr) stall_errs <= stall_errs + 1;
        end
        prev_wait <= flash_valid && !flash_ready;
        prev_addr <= flash_addr;
    end

    task automatic start_req(input logic [23:0] a);
        exp_q.push_back(flash_word(a));
        mem_addr  = a;
        mem_valid = 1'b1;
    endtask

    task automatic wait_resp(input string nm, output int lat);
        logic [31:0] e;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mem_ready !== 1'b1 && lat < BUDGET);
        e = exp_q.pop_front();
        n_vec++;
        if (mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s timeout: mem_ready=%b required 1", nm, mem_ready);
        end else if (mem_rdata !== e) begin
            n_err++;
            $display("FAIL %s data: got %h required %h", nm, mem_rdata, e);
        end
        mem_valid = 1'b0;
    endtask

    task automatic do_read(input logic [23:0] a, input logic exp_hit, input string nm, output int lat);
        int m0;
        m0 = miss_cnt;
        start_req(a);
        wait_resp(nm, lat);
        n_vec++;
        if (stat_hit !== exp_hit) begin
            n_err++;
            $display("FAIL %s stat_hit: got %b required %b", nm, stat_hit, exp_hit);
        end
        n_vec++;
        if (miss_cnt - m0 != (exp_hit ? 0 : 1)) begin
            n_err++;
            $display("FAIL %s stat_miss pulses: got %0d required %0d", nm, miss_cnt - m0, exp_hit ? 0 : 1);
        end
    endtask

    task automatic check_line(input int b, input logic [23:0] base, input string nm);
        n_vec++;
        if (flash_cnt - b != 4) begin
            n_err++;
            $display("FAIL %s flash reads: got %0d required 4", nm, flash_cnt - b);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (flash_log[(b + i) % 256] !== base + 24'(4 * i)) begin
                n_err++;
                $display("FAIL %s flash_addr[%0d]: got %h required %h", nm, i, flash_log[(b + i) % 256], base + 24'(4 * i));
            end
        end
    endtask

    task automatic wait_words(input int target, input string nm);
        int t;
        t = 0;
        while (flash_cnt < target && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (flash_cnt < target) begin
            n_err++;
            $display("FAIL %s fill progress: got %0d words required %0d", nm, flash_cnt, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_ready, flash_valid, stat_hit, stat_miss} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0000", {mem_ready, flash_valid, stat_hit, stat_miss});
        end
        n_vec++;
        if (flash_addr !== 24'h0) begin
            n_err++;
            $display("FAIL reset_flash_addr: got %h required 000000", flash_addr);
        end
        n_vec++;
        if (mem_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h required 00000000", mem_rdata);
        end
    endtask

    task automatic test_cold_miss();
        int b, lat;
        b = flash_cnt;
        do_read(24'h000104, 1'b0, "cold_miss", lat);
        check_line(b, 24'h000100, "cold_miss");
        n_vec++;
        if (flash_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cold_miss flash_valid after fill: got %b required 0", flash_valid);
        end
    endtask

    task automatic test_hit();
        int b, lat;
        @(negedge clk);
        b = flash_cnt;
        do_read(24'h00010C, 1'b1, "hit", lat);
        n_vec++;
        if (lat != 2) begin
            n_err++;
            $display("FAIL hit latency: got %0d required 2", lat);
        end
        n_vec++;
        if (flash_cnt != b) begin
            n_err++;
            $display("FAIL hit flash reads: got %0d required 0", flash_cnt - b);
        end
    endtask

    task automatic test_conflict();
        int b, lat;
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        b = flash_cnt;
        do_read(24'h000100, 1'b0, "conflict_a", lat);
        do_read(24'h000200, 1'b0, "conflict_b", lat);
        do_read(24'h000100, 1'b0, "conflict_a2", lat);
        n_vec++;
        if (flash_cnt - b != 12) begin
            n_err++;
            $display("FAIL conflict flash reads: got %0d required 12", flash_cnt - b);
        end
        check_line(b + 8, 24'h000100, "conflict_a2");
    endtask

    task automatic test_flush_fill();
        int b, lat;
        b = flash_cnt;
        start_req(24'h001000);
        wait_words(b + 2, "flush_fill");
        cache_flush = 1'b1;
        @(negedge clk);
        cache_flush = 1'b0;
        wait_resp("flush_fill", lat);
        b = flash_cnt;
        do_read(24'h001000, 1'b0, "flush_reread", lat);
        check_line(b, 24'h001000, "flush_reread");
    endtask

    task automatic test_reset_fill();
        int b, lat;
        b = flash_cnt;
        start_req(24'h002040);
        wait_words(b + 2, "reset_fill");
        reset     = 1'b1;
        mem_valid = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        n_vec++;
        if ({flash_valid, mem_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_fill outputs: flash_valid,mem_ready=%b required 00", {flash_valid, mem_ready});
        end
        @(negedge clk);
        b = flash_cnt;
        do_read(24'h002044, 1'b0, "reset_reread", lat);
        check_line(b, 24'h002040, "reset_reread");
    endtask

    task automatic test_stall();
        int b, lat, c0;
        max_stall = 40;
        c0 = stall_checks;
        b = flash_cnt;
        do_read(24'h003008, 1'b0, "stall", lat);
        check_line(b, 24'h003000, "stall");
        max_stall = 0;
        @(negedge clk);
        n_vec++;
        if (stall_errs != 0 || stall_checks == c0) begin
            n_err++;
            $display("FAIL stall addr_stable: errors=%0d checks=%0d required errors=0 checks>0", stall_errs, stall_checks - c0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_read(24'h003000 + 24'(4 * i), 1'b1, "b2b", lat);
        end
        @(negedge clk);
        n_vec++;
        if (mem_ready !== 1'b0 || mem_rdata !== flash_word(24'h00300C)) begin
            n_err++;
            $display("FAIL b2b hold: mem_ready=%b rdata=%h required 0/%h", mem_ready, mem_rdata, flash_word(24'h00300C));
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_fill();
        test_reset_fill();
        test_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
